// File: rtl/spi_pkg.sv
// Shared types and defaults for the burst-capable SPI slave sequencer.
// The state encoding fills all eight 3-bit codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_GET       = 3'd0,
    ST_GOT       = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RD_LOAD   = 3'd3,
    ST_RD_SHIFT  = 3'd4,
    ST_WR_SHIFT  = 3'd5,
    ST_WR_COMMIT = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_burst_fsm_if.sv
// Control/status bundle between the SPI input conditioners and the sequencer.
// The master side drives the frame controls; the slave side is the sequencer.
interface spi_burst_fsm_if #(
  parameter int CNT_W = 3
);
  logic             chipselect;
  logic             readwrite;
  logic             burst;
  logic             shiftRegWriteEnable;
  logic             dataMemWriteEnable;
  logic             addressLatchEnable;
  logic             addrIncEnable;
  logic             misoEnable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] wordCount;

  modport master (
    output chipselect, readwrite, burst,
    input  shiftRegWriteEnable, dataMemWriteEnable, addressLatchEnable,
           addrIncEnable, misoEnable, busy, done, wordCount
  );

  modport slave (
    input  chipselect, readwrite, burst,
    output shiftRegWriteEnable, dataMemWriteEnable, addressLatchEnable,
           addrIncEnable, misoEnable, busy, done, wordCount
  );
endinterface

// File: rtl/spi_bit_counter.sv
// Bit counter that wraps to zero on its terminal value.
// last_o flags the final bit of the current phase.
module spi_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == term_i);

  // Count enabled bits; wrap on the terminal value so the next phase starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (last_o) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + W'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/spi_burst_fsm.sv
// SPI slave frame sequencer: address phase, then one or more read/write data words.
// All outputs are registered and reflect the state the last edge was taken from.
module spi_burst_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic          sclk,
  input  logic          rst_n,
  spi_burst_fsm_if.slave bus
);

  localparam int BIT_W = $clog2(max_int(ADDR_W, DATA_W));
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic             BURST_OK  = (MAX_BURST > 1) ? 1'b1 : 1'b0;

  state_e           state_q;
  logic [CNT_W-1:0] wc_q;
  logic             burst_mode_q;
  logic             sre_q;
  logic             dme_q;
  logic             ale_q;
  logic             aie_q;
  logic             miso_q;
  logic             busy_q;
  logic             done_q;

  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [BIT_W-1:0] cnt_term_s;
  logic [BIT_W-1:0] bit_cnt_s;
  logic             last_bit_s;
  logic             more_words_s;

  // Decide which phase the bit counter is timing and its terminal value.
  always_comb begin
    cnt_clr_s  = bus.chipselect;
    cnt_en_s   = 1'b0;
    cnt_term_s = ADDR_LAST;
    case (state_q)
      ST_GET: begin
        cnt_en_s   = 1'b1;
        cnt_term_s = ADDR_LAST;
      end
      ST_RD_SHIFT, ST_WR_SHIFT: begin
        cnt_en_s   = 1'b1;
        cnt_term_s = DATA_LAST;
      end
      ST_GOT, ST_RD_WAIT, ST_RD_LOAD, ST_WR_COMMIT, ST_DONE: begin
        cnt_en_s   = 1'b0;
        cnt_term_s = ADDR_LAST;
      end
      default: begin
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  spi_bit_counter #(
    .W (BIT_W)
  ) u_bit_cnt (
    .clk    (sclk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_i (cnt_term_s),
    .cnt_o  (bit_cnt_s),
    .last_o (last_bit_s)
  );

  // wc_q is still the pre-increment count when a word completes.
  assign more_words_s = burst_mode_q &&
                        ((32'(wc_q) + 32'd1) < 32'(MAX_BURST));

  // Frame state machine with registered enables; chipselect aborts everything.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GET;
      wc_q         <= '0;
      burst_mode_q <= 1'b0;
      sre_q        <= 1'b0;
      dme_q        <= 1'b0;
      ale_q        <= 1'b0;
      aie_q        <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.chipselect) begin
      state_q      <= ST_GET;
      wc_q         <= '0;
      burst_mode_q <= 1'b0;
      sre_q        <= 1'b0;
      dme_q        <= 1'b0;
      ale_q        <= 1'b0;
      aie_q        <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sre_q  <= 1'b0;
      dme_q  <= 1'b0;
      ale_q  <= 1'b0;
      aie_q  <= 1'b0;
      miso_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_GET: begin
          if (last_bit_s) begin
            state_q <= ST_GOT;
          end else begin
            state_q <= ST_GET;
          end
        end
        ST_GOT: begin
          ale_q        <= 1'b1;
          busy_q       <= 1'b1;
          burst_mode_q <= bus.burst && BURST_OK;
          state_q      <= bus.readwrite ? ST_RD_WAIT : ST_WR_SHIFT;
        end
        ST_RD_WAIT: begin
          busy_q  <= 1'b1;
          state_q <= ST_RD_LOAD;
        end
        ST_RD_LOAD: begin
          sre_q   <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ST_RD_SHIFT;
        end
        ST_RD_SHIFT: begin
          miso_q <= 1'b1;
          busy_q <= 1'b1;
          if (last_bit_s) begin
            wc_q <= wc_q + CNT_W'(1);
            if (more_words_s) begin
              aie_q   <= 1'b1;
              state_q <= ST_RD_WAIT;
            end else begin
              state_q <= ST_DONE;
            end
          end else begin
            state_q <= ST_RD_SHIFT;
          end
        end
        ST_WR_SHIFT: begin
          busy_q <= 1'b1;
          if (last_bit_s) begin
            state_q <= ST_WR_COMMIT;
          end else begin
            state_q <= ST_WR_SHIFT;
          end
        end
        ST_WR_COMMIT: begin
          // The increment pulse lands with the write, so memory sees the old address.
          dme_q  <= 1'b1;
          busy_q <= 1'b1;
          wc_q   <= wc_q + CNT_W'(1);
          if (more_words_s) begin
            aie_q   <= 1'b1;
            state_q <= ST_WR_SHIFT;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: begin
          state_q      <= ST_GET;
          wc_q         <= '0;
          burst_mode_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shiftRegWriteEnable = sre_q;
  assign bus.dataMemWriteEnable  = dme_q;
  assign bus.addressLatchEnable  = ale_q;
  assign bus.addrIncEnable       = aie_q;
  assign bus.misoEnable          = miso_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.wordCount           = wc_q;

endmodule

// File: tb/tb_spi_burst_fsm.sv
// Directed bench for spi_burst_fsm: three instances (default, no-burst, wide)
// share one stimulus; per-edge tables plus sequences for bursts and async reset.
module tb_spi_burst_fsm;

  localparam logic [6:0] SRE  = 7'b1000000;
  localparam logic [6:0] DME  = 7'b0100000;
  localparam logic [6:0] ALE  = 7'b0010000;
  localparam logic [6:0] AIE  = 7'b0001000;
  localparam logic [6:0] MISO = 7'b0000100;
  localparam logic [6:0] BUSY = 7'b0000010;
  localparam logic [6:0] DONE = 7'b0000001;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  logic cs    = 1'b1;
  logic rw    = 1'b0;
  logic bst   = 1'b0;

  always #5 sclk = ~sclk;

  spi_burst_fsm_if #(.CNT_W(3)) ifa ();
  spi_burst_fsm_if #(.CNT_W(1)) ifb ();
  spi_burst_fsm_if #(.CNT_W(3)) ifc ();

  assign ifa.chipselect = cs;  assign ifa.readwrite = rw;  assign ifa.burst = bst;
  assign ifb.chipselect = cs;  assign ifb.readwrite = rw;  assign ifb.burst = bst;
  assign ifc.chipselect = cs;  assign ifc.readwrite = rw;  assign ifc.burst = bst;

  spi_burst_fsm #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4), .CNT_W(3)) dut_a (
    .sclk (sclk), .rst_n (rst_n), .bus (ifa.slave));
  spi_burst_fsm #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(1), .CNT_W(1)) dut_b (
    .sclk (sclk), .rst_n (rst_n), .bus (ifb.slave));
  spi_burst_fsm #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(4), .CNT_W(3)) dut_c (
    .sclk (sclk), .rst_n (rst_n), .bus (ifc.slave));

  logic [6:0] obs [3];
  logic [7:0] wcs [3];

  assign obs[0] = {ifa.shiftRegWriteEnable, ifa.dataMemWriteEnable, ifa.addressLatchEnable,
                   ifa.addrIncEnable, ifa.misoEnable, ifa.busy, ifa.done};
  assign obs[1] = {ifb.shiftRegWriteEnable, ifb.dataMemWriteEnable, ifb.addressLatchEnable,
                   ifb.addrIncEnable, ifb.misoEnable, ifb.busy, ifb.done};
  assign obs[2] = {ifc.shiftRegWriteEnable, ifc.dataMemWriteEnable, ifc.addressLatchEnable,
                   ifc.addrIncEnable, ifc.misoEnable, ifc.busy, ifc.done};
  assign wcs[0] = 8'(ifa.wordCount);
  assign wcs[1] = 8'(ifb.wordCount);
  assign wcs[2] = 8'(ifc.wordCount);

  typedef struct {
    logic       cs;
    logic       rw;
    logic       bst;
    logic [6:0] exp;
    logic [7:0] wc;
  } vec_t;

  vec_t vecs [64];
  int   nvec;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic add(input logic c, input logic r, input logic b,
                     input logic [6:0] e, input logic [7:0] w);
    vecs[nvec] = '{c, r, b, e, w};
    nvec++;
  endtask

  // Entry 0 is a deselect edge; entry n is edge n of the frame.
  task automatic build_read();
    logic [6:0] e;
    logic [7:0] w;
    nvec = 0;
    add(1'b1, 1'b1, 1'b0, 7'd0, 8'd0);
    for (int k = 1; k <= 21; k++) begin
      e = 7'd0;
      w = (k >= 19) ? 8'd1 : 8'd0;
      if (k == 9)             e = ALE | BUSY;
      if (k == 10)            e = BUSY;
      if (k == 11)            e = SRE | BUSY;
      if (k >= 12 && k <= 19) e = MISO | BUSY;
      if (k >= 20)            e = DONE;
      add(1'b0, 1'b1, 1'b0, e, w);
    end
  endtask

  task automatic build_write(input logic b, input int last_edge, input int abort_edge);
    logic [6:0] e;
    logic [7:0] w;
    nvec = 0;
    add(1'b1, 1'b0, b, 7'd0, 8'd0);
    for (int k = 1; k <= last_edge; k++) begin
      e = 7'd0;
      w = (k >= 18) ? 8'd1 : 8'd0;
      if (k == 9)             e = ALE | BUSY;
      if (k >= 10 && k <= 17) e = BUSY;
      if (k == 18)            e = DME | BUSY;
      if (k >= 19)            e = DONE;
      if (k >= abort_edge) begin
        add(1'b1, 1'b0, b, 7'd0, 8'd0);
      end else begin
        add(1'b0, 1'b0, b, e, w);
      end
    end
  endtask

  task automatic run_table(input int sel, input string name);
    for (int i = 0; i < nvec; i++) begin
      cs  = vecs[i].cs;
      rw  = vecs[i].rw;
      bst = vecs[i].bst;
      step();
      check($sformatf("%s e%0d outs", name, i), int'(obs[sel]), int'(vecs[i].exp));
      check($sformatf("%s e%0d wordCount", name, i), int'(wcs[sel]), int'(vecs[i].wc));
    end
  endtask

  initial begin
    int n_edge, sre_n, aie_n, miso_n, done_e, ale_e, miso_first, miso_last;
    int sre_e [4];

    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset outs dut%0d", d), int'(obs[d]), 0);
      check($sformatf("reset wordCount dut%0d", d), int'(wcs[d]), 0);
    end
    @(negedge sclk);
    rst_n = 1'b1;

    build_read();
    run_table(0, "read");
    build_write(1'b0, 20, 99);
    run_table(0, "write");
    build_write(1'b1, 20, 99);
    run_table(1, "burst_write_mb1");
    build_write(1'b0, 14, 13);
    run_table(0, "abort");
    build_read();
    run_table(0, "read_after_abort");

    // Four-word burst read on the default instance.
    cs = 1'b1; step();
    cs = 1'b0; rw = 1'b1; bst = 1'b1;
    n_edge = 0; sre_n = 0; aie_n = 0; miso_n = 0; done_e = 0;
    for (int k = 0; k < 4; k++) sre_e[k] = 0;
    while (done_e == 0 && n_edge < 80) begin
      step();
      n_edge++;
      if ((obs[0] & SRE) != 7'd0) begin
        if (sre_n < 4) sre_e[sre_n] = n_edge;
        sre_n++;
      end
      if ((obs[0] & AIE) != 7'd0)  aie_n++;
      if ((obs[0] & MISO) != 7'd0) miso_n++;
      if ((obs[0] & DONE) != 7'd0) done_e = n_edge;
    end
    check("burst_read done edge", done_e, 50);
    check("burst_read load count", sre_n, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("burst_read load%0d edge", k), sre_e[k], 11 + 10 * k);
    check("burst_read inc count", aie_n, 3);
    check("burst_read miso edges", miso_n, 32);
    check("burst_read wordCount", int'(wcs[0]), 4);

    // Single read on the 16/32-bit instance.
    cs = 1'b1; bst = 1'b0; step();
    cs = 1'b0; rw = 1'b1;
    n_edge = 0; ale_e = 0; sre_n = 0; miso_n = 0; done_e = 0;
    miso_first = 0; miso_last = 0; sre_e[0] = 0;
    while (done_e == 0 && n_edge < 120) begin
      step();
      n_edge++;
      if ((obs[2] & ALE) != 7'd0) ale_e = n_edge;
      if ((obs[2] & SRE) != 7'd0) begin
        sre_e[0] = n_edge;
        sre_n++;
      end
      if ((obs[2] & MISO) != 7'd0) begin
        if (miso_first == 0) miso_first = n_edge;
        miso_last = n_edge;
        miso_n++;
      end
      if ((obs[2] & DONE) != 7'd0) done_e = n_edge;
    end
    check("wide ale edge", ale_e, 17);
    check("wide load edge", sre_e[0], 19);
    check("wide load count", sre_n, 1);
    check("wide miso first", miso_first, 20);
    check("wide miso last", miso_last, 51);
    check("wide miso count", miso_n, 32);
    check("wide done edge", done_e, 52);
    check("wide wordCount", int'(wcs[2]), 1);

    // Asynchronous reset between edges while shifting read data out.
    cs = 1'b1; step();
    cs = 1'b0; rw = 1'b1; bst = 1'b0;
    repeat (14) step();
    check("pre_reset miso", int'(obs[0]), int'(MISO | BUSY));
    check("pre_reset wordCount", int'(wcs[0]), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset outs dut0", int'(obs[0]), 0);
    check("async_reset outs dut2", int'(obs[2]), 0);
    check("async_reset wordCount dut0", int'(wcs[0]), 0);
    @(negedge sclk);
    rst_n = 1'b1;
    build_read();
    run_table(0, "read_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
